// File: rtl/nv_nvdla_cmac_mac_grp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nv_nvdla_cmac_mac_grp_if                                          |
// | Desc   : CSC-to-MAC input bus and MAC-to-CACC result bus for a MAC group.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface nv_nvdla_cmac_mac_grp_if #(
  parameter int ATOMC      = 8,
  parameter int ATOMK_HALF = 4,
  parameter int BPE        = 8
);
  localparam int RW = 2*BPE + $clog2(ATOMC);

  logic                       sc2mac_dat_pvld;
  logic [ATOMC-1:0]           sc2mac_dat_mask;
  logic [ATOMC*BPE-1:0]       sc2mac_dat_data;
  logic [8:0]                 sc2mac_dat_pd;
  logic                       sc2mac_wt_pvld;
  logic [ATOMC-1:0]           sc2mac_wt_mask;
  logic [ATOMC*BPE-1:0]       sc2mac_wt_data;
  logic [ATOMK_HALF-1:0]      sc2mac_wt_sel;
  logic                       mac2accu_pvld;
  logic [ATOMK_HALF-1:0]      mac2accu_mask;
  logic [ATOMK_HALF*RW-1:0]   mac2accu_data;
  logic [8:0]                 mac2accu_pd;

  // Upstream (CSC) and downstream (CACC) side together.
  modport master (
    output sc2mac_dat_pvld, sc2mac_dat_mask, sc2mac_dat_data, sc2mac_dat_pd,
    output sc2mac_wt_pvld, sc2mac_wt_mask, sc2mac_wt_data, sc2mac_wt_sel,
    input  mac2accu_pvld, mac2accu_mask, mac2accu_data, mac2accu_pd
  );

  // MAC group view.
  modport slave (
    input  sc2mac_dat_pvld, sc2mac_dat_mask, sc2mac_dat_data, sc2mac_dat_pd,
    input  sc2mac_wt_pvld, sc2mac_wt_mask, sc2mac_wt_data, sc2mac_wt_sel,
    output mac2accu_pvld, mac2accu_mask, mac2accu_data, mac2accu_pd
  );
endinterface
`default_nettype wire

// File: rtl/nv_nvdla_cmac_mac_grp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : nv_nvdla_cmac_mac_grp                                             |
// | Desc   : Group of masked signed dot-product MAC cells with double-buffered |
// |          weights swapped at stripe boundaries.                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module nv_nvdla_cmac_mac_grp #(
  parameter int ATOMC      = 8,
  parameter int ATOMK_HALF = 4,
  parameter int BPE        = 8,
  parameter int PIPE       = 2
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic                          reg2dp_op_en,
  nv_nvdla_cmac_mac_grp_if.slave        bus,
  output logic                          dp2reg_done
);
  localparam int RW = 2*BPE + $clog2(ATOMC);
  localparam int K  = ATOMK_HALF;

  logic                       op_en_q;
  logic                       stripe_st_q, stripe_st_d;
  logic [ATOMC*BPE-1:0]       shadow_wt_q  [K];
  logic [ATOMC*BPE-1:0]       shadow_wt_d  [K];
  logic [ATOMC-1:0]           shadow_msk_q [K];
  logic [ATOMC-1:0]           shadow_msk_d [K];
  logic [K-1:0]               shadow_vld_q, shadow_vld_d;
  logic [ATOMC*BPE-1:0]       act_wt_q     [K];
  logic [ATOMC*BPE-1:0]       act_wt_d     [K];
  logic [ATOMC-1:0]           act_msk_q    [K];
  logic [ATOMC-1:0]           act_msk_d    [K];
  logic [K-1:0]               act_vld_q, act_vld_d;

  logic                       s0_vld_q, s0_vld_d;
  logic [8:0]                 s0_pd_q, s0_pd_d;
  logic [K-1:0]               s0_mask_q, s0_mask_d;
  logic signed [2*BPE-1:0]    s0_prod_q [K][ATOMC];
  logic signed [2*BPE-1:0]    s0_prod_d [K][ATOMC];

  logic                       pipe_vld_q  [1:PIPE];
  logic                       pipe_vld_d  [1:PIPE];
  logic [8:0]                 pipe_pd_q   [1:PIPE];
  logic [8:0]                 pipe_pd_d   [1:PIPE];
  logic [K-1:0]               pipe_mask_q [1:PIPE];
  logic [K-1:0]               pipe_mask_d [1:PIPE];
  logic [K*RW-1:0]            pipe_data_q [1:PIPE];
  logic [K*RW-1:0]            pipe_data_d [1:PIPE];

  logic                       accept;
  logic                       load;
  logic                       op_rise;
  logic                       stripe_eff;
  logic                       swap;
  logic signed [BPE-1:0]      dat_el;
  logic signed [BPE-1:0]      wt_el;
  logic signed [RW-1:0]       acc;

  assign accept     = bus.sc2mac_dat_pvld & reg2dp_op_en;
  assign load       = bus.sc2mac_wt_pvld & reg2dp_op_en;
  assign op_rise    = reg2dp_op_en & ~op_en_q;
  // A rising enable opens a new stripe even for a beat accepted in that cycle.
  assign stripe_eff = stripe_st_q | op_rise;
  assign swap       = accept & stripe_eff;

  always_comb begin : p_weights
    shadow_wt_d  = shadow_wt_q;
    shadow_msk_d = shadow_msk_q;
    shadow_vld_d = shadow_vld_q;
    act_wt_d     = act_wt_q;
    act_msk_d    = act_msk_q;
    act_vld_d    = act_vld_q;
    stripe_st_d  = accept ? bus.sc2mac_dat_pd[7] : stripe_eff;

    if (swap) begin
      act_wt_d     = shadow_wt_q;
      act_msk_d    = shadow_msk_q;
      act_vld_d    = shadow_vld_q;
      shadow_vld_d = '0;
    end

    // A load in the swap cycle lands after the copy, so it stays in shadow.
    for (int k = 0; k < K; k++) begin
      if (load && bus.sc2mac_wt_sel[k]) begin
        shadow_vld_d[k] = 1'b1;
        shadow_msk_d[k] = bus.sc2mac_wt_mask;
        for (int c = 0; c < ATOMC; c++) begin
          shadow_wt_d[k][c*BPE +: BPE] = bus.sc2mac_wt_mask[c] ?
                                         bus.sc2mac_wt_data[c*BPE +: BPE] : '0;
        end
      end
    end
  end

  // Stage 0 multiplies against the post-swap active set.
  always_comb begin : p_stage0
    dat_el    = '0;
    wt_el     = '0;
    s0_vld_d  = accept;
    s0_pd_d   = accept ? bus.sc2mac_dat_pd : '0;
    s0_mask_d = accept ? act_vld_d : '0;
    for (int k = 0; k < K; k++) begin
      for (int c = 0; c < ATOMC; c++) begin
        dat_el = $signed(bus.sc2mac_dat_data[c*BPE +: BPE]);
        wt_el  = $signed(act_wt_d[k][c*BPE +: BPE]);
        if (accept && act_vld_d[k] && bus.sc2mac_dat_mask[c] && act_msk_d[k][c]) begin
          s0_prod_d[k][c] = dat_el * wt_el;
        end else begin
          s0_prod_d[k][c] = '0;
        end
      end
    end
  end

  // Invalid beats carry zero products, so later stages need no extra gating.
  always_comb begin : p_pipe
    acc         = '0;
    pipe_vld_d  = pipe_vld_q;
    pipe_pd_d   = pipe_pd_q;
    pipe_mask_d = pipe_mask_q;
    pipe_data_d = pipe_data_q;

    pipe_vld_d[1]  = s0_vld_q;
    pipe_pd_d[1]   = s0_pd_q;
    pipe_mask_d[1] = s0_mask_q;
    for (int k = 0; k < K; k++) begin
      acc = '0;
      for (int c = 0; c < ATOMC; c++) begin
        acc = acc + RW'(s0_prod_q[k][c]);
      end
      pipe_data_d[1][k*RW +: RW] = acc;
    end

    for (int i = 2; i <= PIPE; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_pd_d[i]   = pipe_pd_q[i-1];
      pipe_mask_d[i] = pipe_mask_q[i-1];
      pipe_data_d[i] = pipe_data_q[i-1];
    end
  end

  always_ff @(posedge nvdla_core_clk) begin : p_regs
    if (nvdla_core_rst) begin
      op_en_q      <= 1'b0;
      stripe_st_q  <= 1'b1;
      shadow_wt_q  <= '{default: '0};
      shadow_msk_q <= '{default: '0};
      shadow_vld_q <= '0;
      act_wt_q     <= '{default: '0};
      act_msk_q    <= '{default: '0};
      act_vld_q    <= '0;
      s0_vld_q     <= 1'b0;
      s0_pd_q      <= '0;
      s0_mask_q    <= '0;
      s0_prod_q    <= '{default: '{default: '0}};
      pipe_vld_q   <= '{default: 1'b0};
      pipe_pd_q    <= '{default: '0};
      pipe_mask_q  <= '{default: '0};
      pipe_data_q  <= '{default: '0};
    end else begin
      op_en_q      <= reg2dp_op_en;
      stripe_st_q  <= stripe_st_d;
      shadow_wt_q  <= shadow_wt_d;
      shadow_msk_q <= shadow_msk_d;
      shadow_vld_q <= shadow_vld_d;
      act_wt_q     <= act_wt_d;
      act_msk_q    <= act_msk_d;
      act_vld_q    <= act_vld_d;
      s0_vld_q     <= s0_vld_d;
      s0_pd_q      <= s0_pd_d;
      s0_mask_q    <= s0_mask_d;
      s0_prod_q    <= s0_prod_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_pd_q    <= pipe_pd_d;
      pipe_mask_q  <= pipe_mask_d;
      pipe_data_q  <= pipe_data_d;
    end
  end

  assign bus.mac2accu_pvld = pipe_vld_q[PIPE];
  assign bus.mac2accu_mask = pipe_mask_q[PIPE];
  assign bus.mac2accu_data = pipe_data_q[PIPE];
  assign bus.mac2accu_pd   = pipe_pd_q[PIPE];
  assign dp2reg_done       = pipe_vld_q[PIPE] & pipe_pd_q[PIPE][8];

endmodule
`default_nettype wire
